// File: rtl/frag_buffer_ctrl.sv
// Sequencer for the TX fragmentation buffer: admits payload writes for one TLP
// and reads it back out in fully-resident fragments of at most MAX_FRAG_DW.
//
// state | meaning
// IDLE  | waiting for a TLP descriptor (desc_ready=1)
// ARM   | waiting until the next fragment is resident and buf_ready is high
// START | one-cycle start_fragment pulse, no read
// READ  | one location per dl_ready cycle until the fragment's last location
// DONE  | one-cycle tlp_done pulse
module frag_buffer_ctrl #(
  parameter int DW_PER_LOC  = 8,
  parameter int MAX_LOC_WR  = 4,
  parameter int DEPTH       = 32,
  parameter int MAX_FRAG_DW = 128,
  parameter int LEN_W       = 10,
  localparam int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             desc_valid,
  input  logic [LEN_W-1:0] desc_len_dw,
  output logic             desc_ready,
  input  logic             wr_valid,
  input  logic [2:0]       wr_nloc,
  output logic             wr_ready,
  output logic             buf_wr_en,
  output logic [2:0]       buf_no_loc_wr,
  output logic             buf_rd_en,
  output logic             buf_rd_mode,
  input  logic             buf_ready,
  output logic             start_fragment,
  input  logic             dl_ready,
  output logic             frag_sop,
  output logic             frag_eop,
  output logic             tlp_done,
  output logic [OCC_W-1:0] occupancy
);

  localparam int CNT_W    = LEN_W + 1;
  localparam int FRAG_LOC = MAX_FRAG_DW / DW_PER_LOC;

  typedef enum logic [2:0] {IDLE, ARM, START, READ, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tlp_locs, wr_cnt, rd_cnt, frag_len, frag_cnt;
  logic [CNT_W-1:0] len_full, locs_in, wr_left, rd_left, cur_frag, avail;
  logic [OCC_W-1:0] room;
  logic [2:0]       wr_amt;
  logic             load_desc, load_frag, eop_now;

  // A zero length field encodes the maximum, 2**LEN_W DW.
  assign len_full = (desc_len_dw == '0) ? (CNT_W'(1) << LEN_W) : {1'b0, desc_len_dw};
  assign locs_in  = (len_full + CNT_W'(DW_PER_LOC - 1)) / CNT_W'(DW_PER_LOC);

  assign wr_left  = tlp_locs - wr_cnt;
  assign rd_left  = tlp_locs - rd_cnt;
  assign avail    = wr_cnt - rd_cnt;
  assign cur_frag = (rd_left < CNT_W'(FRAG_LOC)) ? rd_left : CNT_W'(FRAG_LOC);
  assign room     = OCC_W'(DEPTH) - occupancy;

  assign wr_ready      = (state != IDLE) && (wr_cnt < tlp_locs) && (room >= OCC_W'(wr_nloc));
  assign wr_amt        = (CNT_W'(wr_nloc) < wr_left) ? wr_nloc : wr_left[2:0];
  assign buf_wr_en     = wr_valid && wr_ready && (wr_nloc != 3'd0);
  assign buf_no_loc_wr = buf_wr_en ? wr_amt : 3'd0;

  always_comb begin
    state_nxt      = state;
    desc_ready     = 1'b0;
    start_fragment = 1'b0;
    buf_rd_en      = 1'b0;
    buf_rd_mode    = 1'b0;
    frag_sop       = 1'b0;
    frag_eop       = 1'b0;
    tlp_done       = 1'b0;
    load_desc      = 1'b0;
    load_frag      = 1'b0;
    eop_now        = 1'b0;
    case (state)
      IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          load_desc = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if ((avail >= cur_frag) && buf_ready) begin
          load_frag = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        start_fragment = 1'b1;
        state_nxt      = READ;
      end
      READ: begin
        // Mode derives from the in-fragment count so it holds across stalls.
        buf_rd_en   = dl_ready;
        buf_rd_mode = (frag_cnt != '0);
        frag_sop    = dl_ready && (frag_cnt == '0);
        eop_now     = dl_ready && (frag_cnt == frag_len - CNT_W'(1));
        frag_eop    = eop_now;
        if (eop_now) begin
          state_nxt = (rd_cnt + CNT_W'(1) == tlp_locs) ? DONE : ARM;
        end
      end
      DONE: begin
        tlp_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      tlp_locs  <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      frag_len  <= '0;
      frag_cnt  <= '0;
      occupancy <= '0;
    end else begin
      state     <= state_nxt;
      occupancy <= occupancy + OCC_W'(buf_no_loc_wr) - OCC_W'(buf_rd_en);
      if (load_desc) begin
        tlp_locs <= locs_in;
        wr_cnt   <= '0;
        rd_cnt   <= '0;
      end else begin
        wr_cnt <= wr_cnt + CNT_W'(buf_no_loc_wr);
        rd_cnt <= rd_cnt + CNT_W'(buf_rd_en);
      end
      if (load_frag) begin
        frag_len <= cur_frag;
        frag_cnt <= '0;
      end else if (buf_rd_en) begin
        frag_cnt <= frag_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frag_buffer_ctrl.sv
// Bench for frag_buffer_ctrl: directed vector table, hand-written corner sequences
// and randomized TLPs scored against a transaction-level reference model.
module tb_frag_buffer_ctrl;
  localparam int DEPTH    = 32;
  localparam int FRAG_LOC = 16;
  localparam int LEN_W    = 10;
  localparam int OCC_W    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             arst;
  logic             desc_valid, desc_ready;
  logic [LEN_W-1:0] desc_len_dw;
  logic             wr_valid, wr_ready, buf_wr_en;
  logic [2:0]       wr_nloc, buf_no_loc_wr;
  logic             buf_rd_en, buf_rd_mode, buf_ready, start_fragment, dl_ready;
  logic             frag_sop, frag_eop, tlp_done;
  logic [OCC_W-1:0] occupancy;

  always #5 clk = ~clk;

  frag_buffer_ctrl dut (
    .clk(clk), .arst(arst),
    .desc_valid(desc_valid), .desc_len_dw(desc_len_dw), .desc_ready(desc_ready),
    .wr_valid(wr_valid), .wr_nloc(wr_nloc), .wr_ready(wr_ready),
    .buf_wr_en(buf_wr_en), .buf_no_loc_wr(buf_no_loc_wr),
    .buf_rd_en(buf_rd_en), .buf_rd_mode(buf_rd_mode), .buf_ready(buf_ready),
    .start_fragment(start_fragment), .dl_ready(dl_ready),
    .frag_sop(frag_sop), .frag_eop(frag_eop), .tlp_done(tlp_done),
    .occupancy(occupancy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int locs_of(input int len);
    int l;
    l = (len == 0) ? 1024 : len;
    return (l + 7) / 8;
  endfunction

  // Reference model: TLP-level bookkeeping of locations written, read and resident.
  bit m_idle;
  int m_locs, m_wr, m_rd, m_occ;
  int n_starts, n_reads, n_done, first_wr, peak_occ;
  bit first_wr_seen, desc_acc_seen;
  bit e_rdy;
  int e_amt, k;

  always @(negedge clk) begin
    if (!arst) begin
      m_idle = 1'b1; m_locs = 0; m_wr = 0; m_rd = 0; m_occ = 0;
      desc_acc_seen = 1'b0;
    end else begin
      e_rdy = !m_idle && (m_wr < m_locs) && ((DEPTH - m_occ) >= int'(wr_nloc));
      e_amt = (wr_valid && e_rdy && wr_nloc != 3'd0) ? imin(int'(wr_nloc), m_locs - m_wr) : 0;
      check("desc_ready", desc_ready, m_idle);
      check("wr_ready", wr_ready, e_rdy);
      check("buf_wr_en", buf_wr_en, e_amt != 0);
      check("buf_no_loc_wr", buf_no_loc_wr, e_amt);
      check("occupancy", occupancy, m_occ);
      if (start_fragment) begin
        check("start_position", m_rd % FRAG_LOC, 0);
        check("store_and_forward", (m_wr - m_rd) >= imin(FRAG_LOC, m_locs - m_rd), 1);
        n_starts++;
      end
      if (buf_rd_en) begin
        k = m_rd;
        check("rd_needs_dl_ready", dl_ready, 1);
        check("rd_in_range", k < m_locs, 1);
        check("frag_sop", frag_sop, (k % FRAG_LOC) == 0);
        check("frag_eop", frag_eop, ((k % FRAG_LOC) == FRAG_LOC - 1) || (k == m_locs - 1));
        check("buf_rd_mode", buf_rd_mode, (k % FRAG_LOC) != 0);
        check("start_before_read", n_starts, k / FRAG_LOC + 1);
        m_rd++;
        n_reads++;
      end else begin
        check("sop_without_read", frag_sop, 0);
        check("eop_without_read", frag_eop, 0);
      end
      if (tlp_done) begin
        check("done_after_all_reads", m_rd, m_locs);
        n_done++;
      end
      if (buf_wr_en && !first_wr_seen) begin
        first_wr = int'(buf_no_loc_wr);
        first_wr_seen = 1'b1;
      end
      if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
      m_occ = m_occ + e_amt - (buf_rd_en ? 1 : 0);
      m_wr  = m_wr + e_amt;
      if (m_idle && desc_valid) begin
        desc_acc_seen = 1'b1;
        m_idle = 1'b0;
        m_locs = locs_of(int'(desc_len_dw));
        m_wr = 0;
        m_rd = 0;
      end
      if (tlp_done) m_idle = 1'b1;
    end
  end

  task automatic clear_stats();
    n_starts = 0; n_reads = 0; peak_occ = 0; first_wr = 0; first_wr_seen = 1'b0;
  endtask

  // Runs one TLP to completion; rnd=0 streams fixed-size beats at full rate.
  task automatic run_tlp(input int len, input int nloc_fix, input bit rnd);
    int done0;
    done0 = n_done;
    @(posedge clk); #1;
    clear_stats();
    desc_len_dw = LEN_W'(len);
    desc_valid  = 1'b1;
    for (int cyc = 0; cyc < 4000 && n_done == done0; cyc++) begin
      wr_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_nloc   = rnd ? 3'($urandom_range(0, 4)) : 3'(nloc_fix);
      dl_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      buf_ready = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      @(posedge clk); #1;
      if (desc_acc_seen) begin
        desc_valid = 1'b0;
        desc_acc_seen = 1'b0;
      end
    end
    check("tlp_completed", n_done - done0, 1);
    desc_valid = 1'b0;
    wr_valid   = 1'b0;
  endtask

  typedef struct {
    int len;
    int nloc;
    int exp_reads;
    int exp_starts;
    int exp_first_wr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int done0, seen, len;
    vecs[0] = '{len: 8,    nloc: 1, exp_reads: 1,   exp_starts: 1, exp_first_wr: 1};
    vecs[1] = '{len: 9,    nloc: 4, exp_reads: 2,   exp_starts: 1, exp_first_wr: 2};
    vecs[2] = '{len: 256,  nloc: 4, exp_reads: 32,  exp_starts: 2, exp_first_wr: 4};
    vecs[3] = '{len: 0,    nloc: 4, exp_reads: 128, exp_starts: 8, exp_first_wr: 4};
    vecs[4] = '{len: 130,  nloc: 3, exp_reads: 17,  exp_starts: 2, exp_first_wr: 3};
    vecs[5] = '{len: 1,    nloc: 2, exp_reads: 1,   exp_starts: 1, exp_first_wr: 1};
    vecs[6] = '{len: 1023, nloc: 4, exp_reads: 128, exp_starts: 8, exp_first_wr: 4};

    arst = 1'b0; desc_valid = 1'b0; desc_len_dw = '0; wr_valid = 1'b0; wr_nloc = '0;
    buf_ready = 1'b0; dl_ready = 1'b0;
    #1;
    check("reset_desc_ready", desc_ready, 1);
    check("reset_wr_ready", wr_ready, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_strobes", {buf_wr_en, buf_rd_en, start_fragment, tlp_done, frag_sop, frag_eop, buf_rd_mode}, 0);
    repeat (2) @(posedge clk);
    #3 arst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_tlp(vecs[i].len, vecs[i].nloc, 1'b0);
      check("vec_reads", n_reads, vecs[i].exp_reads);
      check("vec_starts", n_starts, vecs[i].exp_starts);
      check("vec_first_wr", first_wr, vecs[i].exp_first_wr);
      check("vec_peak_occ_bound", peak_occ <= DEPTH, 1);
    end

    // Fragment resident but buf_ready low: must hold in ARM.
    @(posedge clk); #1;
    clear_stats();
    done0 = n_done;
    buf_ready = 1'b0; dl_ready = 1'b1;
    desc_len_dw = LEN_W'(128); desc_valid = 1'b1;
    wr_valid = 1'b1; wr_nloc = 3'd4;
    @(posedge clk); #1;
    desc_valid = 1'b0; desc_acc_seen = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("t5_hold_no_start", n_starts, 0);
    check("t5_hold_no_read", n_reads, 0);
    buf_ready = 1'b1;
    @(negedge clk);
    check("t5_still_arm", start_fragment, 0);
    @(negedge clk);
    check("t5_start_next", start_fragment, 1);
    seen = 0;
    for (int i = 0; i < 64 && seen < 16; i++) begin
      @(posedge clk); #1;
      dl_ready = (i % 2 == 0);
      @(negedge clk);
      check("t5_rd_follows_dl", buf_rd_en, dl_ready);
      if (buf_rd_en) seen++;
    end
    check("t5_reads", seen, 16);
    for (int i = 0; i < 8 && n_done == done0; i++) @(posedge clk);
    #1;
    check("t5_done", n_done - done0, 1);
    wr_valid = 1'b0;

    // Reset in the middle of a fragment read.
    @(posedge clk); #1;
    clear_stats();
    done0 = n_done;
    dl_ready = 1'b1; buf_ready = 1'b1;
    desc_len_dw = LEN_W'(256); desc_valid = 1'b1;
    wr_valid = 1'b1; wr_nloc = 3'd4;
    @(posedge clk); #1;
    desc_valid = 1'b0; desc_acc_seen = 1'b0;
    for (int i = 0; i < 200 && m_rd < 5; i++) begin
      @(posedge clk); #1;
    end
    check("t6_reached_rd5", m_rd, 5);
    #2 arst = 1'b0;
    #1;
    check("t6_rd_en", buf_rd_en, 0);
    check("t6_occupancy", occupancy, 0);
    check("t6_desc_ready", desc_ready, 1);
    check("t6_strobes", {wr_ready, buf_wr_en, start_fragment, tlp_done, frag_sop, frag_eop, buf_rd_mode}, 0);
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 arst = 1'b1;
    repeat (2) @(posedge clk);
    check("t6_no_done", n_done - done0, 0);
    run_tlp(8, 1, 1'b0);
    check("t6_fresh_reads", n_reads, 1);
    check("t6_fresh_starts", n_starts, 1);

    for (int i = 0; i < 12; i++) begin
      len = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 64) : $urandom_range(0, 1023);
      run_tlp(len, 0, 1'b1);
      check("rnd_reads", n_reads, locs_of(len));
      check("rnd_starts", n_starts, (locs_of(len) + FRAG_LOC - 1) / FRAG_LOC);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
